// File: rtl/blob_bbox_locator_pkg.sv
// Shared definitions for the blob bounding-box locator.
// Holds the FSM state encoding, the default coordinate width, the background
// label and the helpers that pack/unpack a {y, x} point into one word.
package blob_bbox_locator_pkg;

  localparam int unsigned CoordWDefault = 16;
  // Widest coordinate the pack/unpack helpers support; callers truncate.
  localparam int unsigned CoordMaxW     = 32;
  localparam int unsigned BgLabel       = 0;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StActive = 2'd1,
    StLatch  = 2'd2
  } state_e;

  typedef logic [2*CoordMaxW-1:0] pt_word_t;

  // Returns {y, x} with x in the low coord_w bits and y directly above it.
  function automatic pt_word_t pack_pt(input logic [CoordMaxW-1:0] y,
                                       input logic [CoordMaxW-1:0] x,
                                       input int unsigned          coord_w);
    pt_word_t w;
    w = (pt_word_t'(y) << coord_w) | pt_word_t'(x);
    return w;
  endfunction

  function automatic logic [CoordMaxW-1:0] unpack_x(input pt_word_t    w,
                                                   input int unsigned coord_w);
    pt_word_t m;
    m = (pt_word_t'(1) << coord_w) - pt_word_t'(1);
    return CoordMaxW'(w & m);
  endfunction

  function automatic logic [CoordMaxW-1:0] unpack_y(input pt_word_t    w,
                                                   input int unsigned coord_w);
    pt_word_t m;
    m = (pt_word_t'(1) << coord_w) - pt_word_t'(1);
    return CoordMaxW'((w >> coord_w) & m);
  endfunction

endpackage

// File: rtl/blob_bbox_locator_if.sv
// Frame-control, pixel-stream and result bundle of the blob bounding-box locator.
// master: frame source / result reader (drives start, dims, threshold, pixels).
// slave:  the locator (drives busy, done and the published boxes).
interface blob_bbox_locator_if
  import blob_bbox_locator_pkg::*;
#(
  parameter int unsigned N_CLASSES = 3,
  parameter int unsigned LABEL_W   = 2,
  parameter int unsigned COORD_W   = CoordWDefault,
  parameter int unsigned CNT_W     = 24
);

  logic                           start;
  logic [COORD_W-1:0]             columns;
  logic [COORD_W-1:0]             rows;
  logic [CNT_W-1:0]               min_pixels;
  logic                           pix_valid;
  logic [LABEL_W-1:0]             pix_label;
  logic                           busy;
  logic                           done;
  logic [N_CLASSES*2*COORD_W-1:0] out_p1;
  logic [N_CLASSES*2*COORD_W-1:0] out_p2;
  logic [N_CLASSES*CNT_W-1:0]     out_count;
  logic [N_CLASSES-1:0]           out_found;

  modport master (
    output start, columns, rows, min_pixels, pix_valid, pix_label,
    input  busy, done, out_p1, out_p2, out_count, out_found
  );

  modport slave (
    input  start, columns, rows, min_pixels, pix_valid, pix_label,
    output busy, done, out_p1, out_p2, out_count, out_found
  );

endinterface

// File: rtl/bbox_class_acc.sv
// Per-class accumulator: bounding box extremes and saturating pixel count.
// Ports: clock/reset; clear_i resets the box to empty (min all-ones, max 0,
// count 0) and wins over hit_i; hit_i folds (x_i, y_i) into the box.
// Outputs xmin_o/xmax_o/ymin_o/ymax_o/count_o are the live register values.
module bbox_class_acc #(
  parameter int unsigned COORD_W = 16,
  parameter int unsigned CNT_W   = 24
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               clear_i,
  input  logic               hit_i,
  input  logic [COORD_W-1:0] x_i,
  input  logic [COORD_W-1:0] y_i,
  output logic [COORD_W-1:0] xmin_o,
  output logic [COORD_W-1:0] xmax_o,
  output logic [COORD_W-1:0] ymin_o,
  output logic [COORD_W-1:0] ymax_o,
  output logic [CNT_W-1:0]   count_o
);

  logic [COORD_W-1:0] xmin_q, xmin_d, xmax_q, xmax_d;
  logic [COORD_W-1:0] ymin_q, ymin_d, ymax_q, ymax_d;
  logic [CNT_W-1:0]   count_q, count_d;

  always_comb begin
    xmin_d  = xmin_q;
    xmax_d  = xmax_q;
    ymin_d  = ymin_q;
    ymax_d  = ymax_q;
    count_d = count_q;
    if (clear_i) begin
      xmin_d  = '1;
      ymin_d  = '1;
      xmax_d  = '0;
      ymax_d  = '0;
      count_d = '0;
    end else if (hit_i) begin
      if (x_i < xmin_q) xmin_d = x_i;
      if (x_i > xmax_q) xmax_d = x_i;
      if (y_i < ymin_q) ymin_d = y_i;
      if (y_i > ymax_q) ymax_d = y_i;
      if (count_q != '1) count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      xmin_q  <= '1;
      ymin_q  <= '1;
      xmax_q  <= '0;
      ymax_q  <= '0;
      count_q <= '0;
    end else begin
      xmin_q  <= xmin_d;
      ymin_q  <= ymin_d;
      xmax_q  <= xmax_d;
      ymax_q  <= ymax_d;
      count_q <= count_d;
    end
  end

  assign xmin_o  = xmin_q;
  assign xmax_o  = xmax_q;
  assign ymin_o  = ymin_q;
  assign ymax_o  = ymax_q;
  assign count_o = count_q;

endmodule

// File: rtl/blob_bbox_locator.sv
// Streaming per-class bounding-box locator.
// Consumes one labelled pixel per cycle in raster order, tracks per-class
// box and pixel count, and publishes all boxes with a single-cycle done.
// Ports: clock, reset (async, active high); bus (slave) carries start,
// columns, rows, min_pixels, pix_valid, pix_label in and busy, done,
// out_p1 {ymin,xmin}, out_p2 {ymax,xmax}, out_count, out_found out.
module blob_bbox_locator
  import blob_bbox_locator_pkg::*;
#(
  parameter int unsigned N_CLASSES = 3,
  parameter int unsigned LABEL_W   = 2,
  parameter int unsigned COORD_W   = CoordWDefault,
  parameter int unsigned CNT_W     = 24
) (
  input logic               clock,
  input logic               reset,
  blob_bbox_locator_if.slave bus
);

  localparam int unsigned PtW = 2 * COORD_W;

  state_e             state_q, state_d;
  logic [COORD_W-1:0] cols_q, cols_d, rows_q, rows_d;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic [CNT_W-1:0]   minpix_q, minpix_d;
  logic               busy_q, busy_d, done_q, done_d;

  logic [N_CLASSES*PtW-1:0]   p1_q, p1_d, p2_q, p2_d;
  logic [N_CLASSES*CNT_W-1:0] cnt_q, cnt_d;
  logic [N_CLASSES-1:0]       found_q, found_d;

  logic                 load, acc_clear, pix_take;
  logic [N_CLASSES-1:0] hit;

  logic [COORD_W-1:0] xmin [N_CLASSES];
  logic [COORD_W-1:0] xmax [N_CLASSES];
  logic [COORD_W-1:0] ymin [N_CLASSES];
  logic [COORD_W-1:0] ymax [N_CLASSES];
  logic [CNT_W-1:0]   count [N_CLASSES];

  // FSM and raster counters. A start with a valid geometry always (re)loads,
  // so a start during ACTIVE drops the current pixel and aborts that frame.
  always_comb begin
    state_d   = state_q;
    cols_d    = cols_q;
    rows_d    = rows_q;
    minpix_d  = minpix_q;
    x_d       = x_q;
    y_d       = y_q;
    load      = 1'b0;
    pix_take  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start && bus.columns != '0 && bus.rows != '0) begin
          load    = 1'b1;
          state_d = StActive;
        end
      end
      StActive: begin
        if (bus.start && bus.columns != '0 && bus.rows != '0) begin
          load = 1'b1;
        end else if (bus.pix_valid) begin
          pix_take = 1'b1;
          if (x_q == cols_q - COORD_W'(1)) begin
            x_d = '0;
            if (y_q == rows_q - COORD_W'(1)) state_d = StLatch;
            else                             y_d     = y_q + COORD_W'(1);
          end else begin
            x_d = x_q + COORD_W'(1);
          end
        end
      end
      StLatch: state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (load) begin
      cols_d   = bus.columns;
      rows_d   = bus.rows;
      minpix_d = bus.min_pixels;
      x_d      = '0;
      y_d      = '0;
    end
    acc_clear = load;
    // Busy stays up through the done cycle.
    busy_d = (state_d != StIdle) || (state_q == StLatch);
  end

  always_comb begin
    hit = '0;
    for (int c = 0; c < N_CLASSES; c++) begin
      hit[c] = pix_take && (bus.pix_label != LABEL_W'(BgLabel)) &&
               (bus.pix_label == LABEL_W'(c + 1));
    end
  end

  for (genvar c = 0; c < N_CLASSES; c++) begin : g_cls
    bbox_class_acc #(
      .COORD_W (COORD_W),
      .CNT_W   (CNT_W)
    ) u_acc (
      .clock   (clock),
      .reset   (reset),
      .clear_i (acc_clear),
      .hit_i   (hit[c]),
      .x_i     (x_q),
      .y_i     (y_q),
      .xmin_o  (xmin[c]),
      .xmax_o  (xmax[c]),
      .ymin_o  (ymin[c]),
      .ymax_o  (ymax[c]),
      .count_o (count[c])
    );
  end

  // Result publication: accumulators are final once LATCH is reached.
  always_comb begin
    p1_d    = p1_q;
    p2_d    = p2_q;
    cnt_d   = cnt_q;
    found_d = found_q;
    done_d  = 1'b0;
    if (state_q == StLatch) begin
      done_d = 1'b1;
      for (int c = 0; c < N_CLASSES; c++) begin
        if (count[c] != '0) begin
          p1_d[c*PtW +: PtW] = PtW'(pack_pt(CoordMaxW'(ymin[c]), CoordMaxW'(xmin[c]), COORD_W));
          p2_d[c*PtW +: PtW] = PtW'(pack_pt(CoordMaxW'(ymax[c]), CoordMaxW'(xmax[c]), COORD_W));
        end else begin
          p1_d[c*PtW +: PtW] = '0;
          p2_d[c*PtW +: PtW] = '0;
        end
        cnt_d[c*CNT_W +: CNT_W] = count[c];
        found_d[c] = (count[c] != '0) && (count[c] >= minpix_q);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      cols_q   <= '0;
      rows_q   <= '0;
      minpix_q <= '0;
      x_q      <= '0;
      y_q      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      p1_q     <= '0;
      p2_q     <= '0;
      cnt_q    <= '0;
      found_q  <= '0;
    end else begin
      state_q  <= state_d;
      cols_q   <= cols_d;
      rows_q   <= rows_d;
      minpix_q <= minpix_d;
      x_q      <= x_d;
      y_q      <= y_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      p1_q     <= p1_d;
      p2_q     <= p2_d;
      cnt_q    <= cnt_d;
      found_q  <= found_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.out_p1    = p1_q;
  assign bus.out_p2    = p2_q;
  assign bus.out_count = cnt_q;
  assign bus.out_found = found_q;

endmodule

// File: tb/tb_blob_bbox_locator.sv
// Scoreboard bench for blob_bbox_locator: two instances (3 classes / 24-bit
// counts, and 2 classes / 4-bit counts), directed frames, expected results
// queued by the stimulus and checked by per-instance done monitors.
module tb_blob_bbox_locator;

  typedef struct packed {
    logic [95:0] p1;
    logic [95:0] p2;
    logic [71:0] cnt;
    logic [2:0]  found;
    int          lat;
  } exp_t;

  logic clock = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   start_a = 0;
  int   start_b = 0;
  exp_t q_a[$];
  exp_t q_b[$];
  exp_t ea, eb;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  blob_bbox_locator_if #(.N_CLASSES(3), .LABEL_W(2), .COORD_W(16), .CNT_W(24)) if_a ();
  blob_bbox_locator_if #(.N_CLASSES(2), .LABEL_W(2), .COORD_W(16), .CNT_W(4)) if_b ();

  blob_bbox_locator #(.N_CLASSES(3), .LABEL_W(2), .COORD_W(16), .CNT_W(24)) dut_a (
    .clock (clock),
    .reset (reset),
    .bus   (if_a)
  );

  blob_bbox_locator #(.N_CLASSES(2), .LABEL_W(2), .COORD_W(16), .CNT_W(4)) dut_b (
    .clock (clock),
    .reset (reset),
    .bus   (if_b)
  );

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mkpt(input int y, input int x);
    return {y[15:0], x[15:0]};
  endfunction

  // 1: rectangle x10..19/y5..14 as class 1, (79,59) as class 2.
  // 2: everything class 1.  3: column 0 -> 1, 1 -> 3, 2 -> 2, else 0.
  function automatic logic [1:0] lab(input int mode, input int x, input int y);
    case (mode)
      1: begin
        if (x >= 10 && x <= 19 && y >= 5 && y <= 14) return 2'd1;
        if (x == 79 && y == 59) return 2'd2;
        return 2'd0;
      end
      2: return 2'd1;
      3: begin
        case (x)
          0:       return 2'd1;
          1:       return 2'd3;
          2:       return 2'd2;
          default: return 2'd0;
        endcase
      end
      default: return 2'd0;
    endcase
  endfunction

  always @(negedge clock) begin
    if (!reset && if_a.done) begin
      if (q_a.size() == 0) begin
        chk("a_unexpected_done", 96'(if_a.done), 96'd0);
      end else begin
        ea = q_a.pop_front();
        chk("a_p1", 96'(if_a.out_p1), ea.p1);
        chk("a_p2", 96'(if_a.out_p2), ea.p2);
        chk("a_count", 96'(if_a.out_count), 96'(ea.cnt));
        chk("a_found", 96'(if_a.out_found), 96'(ea.found));
        chk("a_latency", 96'(cyc - start_a), 96'(ea.lat));
        chk("a_busy_at_done", 96'(if_a.busy), 96'd1);
      end
    end
    if (!reset && if_b.done) begin
      if (q_b.size() == 0) begin
        chk("b_unexpected_done", 96'(if_b.done), 96'd0);
      end else begin
        eb = q_b.pop_front();
        chk("b_p1", 96'(if_b.out_p1), eb.p1);
        chk("b_p2", 96'(if_b.out_p2), eb.p2);
        chk("b_count", 96'(if_b.out_count), 96'(eb.cnt));
        chk("b_found", 96'(if_b.out_found), 96'(eb.found));
        chk("b_latency", 96'(cyc - start_b), 96'(eb.lat));
      end
    end
  end

  // Called and returning at #1 after a rising edge.
  task automatic run_a(input int cols, input int rows, input int minp, input int mode,
                       input int stop_at, input bit gaps, input bit push, input exp_t e);
    int n = 0;
    int g = 0;
    if_a.columns    = 16'(cols);
    if_a.rows       = 16'(rows);
    if_a.min_pixels = 24'(minp);
    if_a.start      = 1'b1;
    @(posedge clock); #1;
    if_a.start = 1'b0;
    if (push) start_a = cyc;
    for (int y = 0; y < rows; y++) begin
      for (int x = 0; x < cols; x++) begin
        if (gaps && (n % 7) == 3) begin
          if_a.pix_valid = 1'b0;
          if_a.pix_label = 2'd1;
          @(posedge clock); #1;
          g++;
        end
        if_a.pix_valid = 1'b1;
        if_a.pix_label = lab(mode, x, y);
        @(posedge clock); #1;
        n++;
        if (stop_at != 0 && n == stop_at) begin
          if_a.pix_valid = 1'b0;
          return;
        end
      end
    end
    if_a.pix_valid = 1'b0;
    if (push) begin
      e.lat = cols * rows + 1 + g;
      q_a.push_back(e);
    end
  endtask

  task automatic run_b(input int cols, input int rows, input int minp, input int mode,
                       input exp_t e);
    if_b.columns    = 16'(cols);
    if_b.rows       = 16'(rows);
    if_b.min_pixels = 4'(minp);
    if_b.start      = 1'b1;
    @(posedge clock); #1;
    if_b.start = 1'b0;
    start_b    = cyc;
    for (int y = 0; y < rows; y++) begin
      for (int x = 0; x < cols; x++) begin
        if_b.pix_valid = 1'b1;
        if_b.pix_label = lab(mode, x, y);
        @(posedge clock); #1;
      end
    end
    if_b.pix_valid = 1'b0;
    e.lat = cols * rows + 1;
    q_b.push_back(e);
  endtask

  task automatic drain(input string nm);
    int i = 0;
    while ((q_a.size() != 0 || q_b.size() != 0) && i < 50) begin
      @(posedge clock);
      i++;
    end
    #1;
    n_tests++;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      n_fail++;
      $display("FAIL %s_done_timeout: got %0d results pending required 0", nm,
               q_a.size() + q_b.size());
      q_a.delete();
      q_b.delete();
    end
    repeat (2) @(posedge clock);
    #1;
  endtask

  task automatic chk_zero_a(input string nm);
    chk({nm, "_a_p1"}, 96'(if_a.out_p1), 96'd0);
    chk({nm, "_a_p2"}, 96'(if_a.out_p2), 96'd0);
    chk({nm, "_a_count"}, 96'(if_a.out_count), 96'd0);
    chk({nm, "_a_found"}, 96'(if_a.out_found), 96'd0);
    chk({nm, "_a_busy"}, 96'(if_a.busy), 96'd0);
    chk({nm, "_a_done"}, 96'(if_a.done), 96'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish required finish by cycle %0d", cyc);
    $fatal(1, "bench timeout");
  end

  initial begin
    exp_t z, e2, e3, es, el;
    z  = '0;
    e2 = '0;
    e2.p1    = {32'h0, mkpt(59, 79), mkpt(5, 10)};
    e2.p2    = {32'h0, mkpt(59, 79), mkpt(14, 19)};
    e2.cnt   = {24'd0, 24'd1, 24'd100};
    e2.found = 3'b011;
    e3       = e2;
    e3.found = 3'b001;
    es       = '0;
    es.p1    = {64'h0, 32'h0, mkpt(0, 0)};
    es.p2    = {64'h0, 32'h0, mkpt(4, 3)};
    es.cnt   = {64'h0, 4'd0, 4'd15};
    es.found = 3'b001;
    el       = '0;
    el.p1    = {32'h0, mkpt(0, 2), mkpt(0, 0)};
    el.p2    = {32'h0, mkpt(4, 2), mkpt(4, 0)};
    el.cnt   = {64'h0, 4'd5, 4'd5};
    el.found = 3'b011;

    reset = 1'b1;
    if_a.start = 1'b0; if_a.columns = '0; if_a.rows = '0; if_a.min_pixels = '0;
    if_a.pix_valid = 1'b0; if_a.pix_label = '0;
    if_b.start = 1'b0; if_b.columns = '0; if_b.rows = '0; if_b.min_pixels = '0;
    if_b.pix_valid = 1'b0; if_b.pix_label = '0;
    #2;
    chk_zero_a("reset");
    chk("reset_b_count", 96'(if_b.out_count), 96'd0);
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(posedge clock); #1;

    // Zero-width start must be ignored.
    if_a.columns = 16'd0; if_a.rows = 16'd60; if_a.start = 1'b1;
    @(posedge clock); #1;
    if_a.start = 1'b0;
    repeat (3) @(posedge clock);
    #1 chk("zero_dim_busy", 96'(if_a.busy), 96'd0);

    run_a(80, 60, 1, 0, 0, 1'b0, 1'b1, z);
    drain("all_background");
    run_a(80, 60, 1, 1, 0, 1'b0, 1'b1, e2);
    drain("rect_min1");
    run_a(80, 60, 2, 1, 0, 1'b1, 1'b1, e3);
    drain("rect_min2_gaps");
    // Abort a 40x30 frame at pixel 1000 with a fresh 80x60 start.
    run_a(40, 30, 1, 1, 1000, 1'b0, 1'b0, z);
    run_a(80, 60, 1, 1, 0, 1'b0, 1'b1, e2);
    drain("restart");
    chk("hold_a_count", 96'(if_a.out_count), 96'(e2.cnt));

    run_b(4, 5, 1, 2, es);
    drain("saturate");
    run_b(4, 5, 1, 3, el);
    drain("label3_ignored");
    repeat (5) @(posedge clock);
    #1 chk("hold_b_count", 96'(if_b.out_count), 96'(el.cnt));

    // Reset in the middle of a frame clears everything asynchronously.
    run_a(80, 60, 1, 1, 500, 1'b0, 1'b0, z);
    chk("midframe_busy", 96'(if_a.busy), 96'd1);
    #3 reset = 1'b1;
    #1;
    chk_zero_a("midreset");
    chk("midreset_b_count", 96'(if_b.out_count), 96'd0);
    @(posedge clock); #1 reset = 1'b0;
    repeat (3) @(posedge clock);
    #1 chk("post_reset_busy", 96'(if_a.busy), 96'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
